// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths and entry/pointer types for the UART FIFOs
package uart_pkg;

    localparam int UART_FIFO_DATA_WIDTH = 8;
    localparam int UART_FIFO_ADDR_WIDTH = 4;
    localparam int UART_FIFO_DEPTH      = 2 ** UART_FIFO_ADDR_WIDTH;

    typedef logic [UART_FIFO_DATA_WIDTH-1:0] uart_fifo_data_t;
    // One extra MSB distinguishes full from empty when the low bits match.
    typedef logic [UART_FIFO_ADDR_WIDTH:0]   uart_fifo_ptr_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_WIDTH register file, clocked write, async read
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - UART TX/RX FIFO pointers and status; UART_FIFO_ERR_FLAG_EN adds sticky overflow/underflow
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  clear,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
`ifdef UART_FIFO_ERR_FLAG_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                push_fire;
    logic                pop_fire;

    // Status is decoded from registered pointers only, so push_ready never
    // depends on pop_ready and nothing falls through while empty.
    assign empty      = (wptr == rptr);
    assign full       = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                        (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign count      = wptr - rptr;
    assign push_ready = !full;
    assign pop_valid  = !empty;

    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_valid && pop_ready;

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_fire) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_fire) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

`ifdef UART_FIFO_ERR_FLAG_EN
    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_valid && full) begin
                overflow <= 1'b1;
            end
            if (pop_ready && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    uart_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_fire && rstnn && !clear),
        .wr_addr (wptr[ADDR_WIDTH-1:0]),
        .wr_data (push_data),
        .rd_addr (rptr[ADDR_WIDTH-1:0]),
        .rd_data (pop_data)
    );

endmodule
